// File: rtl/dac_frame_seq.sv
// Purpose: two-entry sample buffer and frame sequencer that feeds the SPI serialiser load port.
// Latency: a sample accepted into an empty buffer with the sequencer idle produces spi_en two clk cycles later.
// Backpressure: s_ready drops while both buffer slots are occupied; a slot is only freed by an issued frame.

// Purpose: generic synchronous FIFO, registered occupancy count, no write-through bypass.
// Latency: a written entry is visible on rd_dat/rd_vld the cycle after the write edge.
// Backpressure: wr_rdy is low when full, even if a read happens in the same cycle.
module dac_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready comes purely from the registered count, so a full FIFO never takes a write
    // in the same cycle it is read.
    assign wr_rdy = (count != CNT_W'(DEPTH));
    assign rd_vld = (count != '0);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && rd_vld;
    assign rd_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end
endmodule

// Purpose: packs buffered {addr,sample} into {CMD,addr,sample} frames and paces them on the serialiser ss line.
// Latency: spi_en two cycles after a sample lands in an empty buffer; next frame waits MIN_GAP cycles after ss rises.
// Backpressure: s_ready = buffer not full; frames wait while spi_ss is low or the sequencer is not idle.
module dac_frame_seq #(
    parameter int         DATA_W  = 12,
    parameter int         ADDR_W  = 4,
    parameter logic [3:0] CMD     = 4'b0011,
    parameter int         MIN_GAP = 2,
    parameter int         TMO     = 8,
    localparam int        FRAME_W = 4 + ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic [ADDR_W-1:0]  s_addr,
    input  logic               resync,
    output logic               spi_en,
    output logic               spi_clr,
    output logic [FRAME_W-1:0] spi_data,
    input  logic               spi_ss,
    output logic               busy,
    output logic               err,
    input  logic               err_clr,
    output logic [15:0]        frames_sent
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        BUSY,
        GAP
    } state_t;

    // One timer serves both the ss-low timeout and the inter-frame gap.
    localparam int TMR_MAX = (TMO > MIN_GAP) ? TMO : MIN_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    entry_t           fifo_in;
    entry_t           fifo_out;
    logic             fifo_vld;
    logic             fifo_pop;
    logic             resync_pend;
    logic             issue_go;
    logic             tmo_hit;

    assign fifo_in.addr = s_addr;
    assign fifo_in.data = s_data;

    dac_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s_valid),
        .wr_rdy (s_ready),
        .wr_dat (fifo_in),
        .rd_vld (fifo_vld),
        .rd_en  (fifo_pop),
        .rd_dat (fifo_out)
    );

    // The issue only goes ahead if ss is still high; a foreign transfer that starts
    // while we are in ISSUE sends us back to IDLE with the entry kept.
    assign issue_go = (state == ISSUE) && spi_ss;
    assign fifo_pop = issue_go;
    assign tmo_hit  = (state == WAIT_LOW) && spi_ss && (timer == TMR_W'(TMO - 1));

    // Resync request latch: out of reset the first frame always carries clr; a new
    // request arriving on the issue cycle survives so the next frame also gets clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resync_pend <= 1'b1;
        end else if (resync) begin
            resync_pend <= 1'b1;
        end else if (issue_go) begin
            resync_pend <= 1'b0;
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (tmo_hit) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Frame sequencer with all load-port outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            spi_en      <= 1'b0;
            spi_clr     <= 1'b0;
            spi_data    <= '0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else begin
            spi_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_vld && spi_ss) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (spi_ss) begin
                        spi_en   <= 1'b1;
                        spi_clr  <= resync_pend;
                        spi_data <= {CMD, fifo_out.addr, fifo_out.data};
                        timer    <= '0;
                        state    <= WAIT_LOW;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (!spi_ss) begin
                        state <= BUSY;
                    end else if (timer == TMR_W'(TMO - 1)) begin
                        // Serialiser never took the frame: drop it, no retry.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BUSY: begin
                    if (spi_ss) begin
                        frames_sent <= frames_sent + 16'd1;
                        timer       <= '0;
                        if (MIN_GAP == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (timer == TMR_W'(MIN_GAP - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dac_frame_seq.sv
// Directed bench for dac_frame_seq with a behavioural serialiser driving spi_ss.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_dac_frame_seq;
    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 4;
    localparam int MIN_GAP = 2;
    localparam int TMO     = 8;
    localparam int FRAME_W = 4 + ADDR_W + DATA_W;

    logic               clk;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic [ADDR_W-1:0]  s_addr;
    logic               resync;
    logic               spi_en;
    logic               spi_clr;
    logic [FRAME_W-1:0] spi_data;
    logic               spi_ss;
    logic               busy;
    logic               err;
    logic               err_clr;
    logic [15:0]        frames_sent;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Serialiser model controls and its record of every load pulse.
    int                 ser_low    = 18;
    bit                 ser_ignore = 1'b0;
    int                 last_rise  = 0;
    bit                 prev_en    = 1'b0;
    logic [FRAME_W-1:0] got_data[$];
    logic               got_clr[$];
    int                 got_cyc[$];
    int                 got_gap[$];

    dac_frame_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .CMD     (4'b0011),
        .MIN_GAP (MIN_GAP),
        .TMO     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_addr      (s_addr),
        .resync      (resync),
        .spi_en      (spi_en),
        .spi_clr     (spi_clr),
        .spi_data    (spi_data),
        .spi_ss      (spi_ss),
        .busy        (busy),
        .err         (err),
        .err_clr     (err_clr),
        .frames_sent (frames_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Serialiser: one cycle after a load pulse it pulls ss low for ser_low cycles.
    initial begin : ser_model
        int ss_cnt;
        bit start_dly;
        ss_cnt    = 0;
        start_dly = 1'b0;
        spi_ss    = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_ss    = 1'b1;
                ss_cnt    = 0;
                start_dly = 1'b0;
                prev_en   = 1'b0;
            end else begin
                if (spi_en === 1'b1) begin
                    checks++;
                    if (prev_en || spi_ss !== 1'b1) begin
                        failures++;
                        $display("FAIL spi_en_pulse: prev_en=%0b ss=%0b, required single-cycle pulse with ss high",
                                 prev_en, spi_ss);
                    end
                    got_data.push_back(spi_data);
                    got_clr.push_back(spi_clr);
                    got_cyc.push_back(cyc);
                    got_gap.push_back(cyc - last_rise);
                    if (!ser_ignore) start_dly = 1'b1;
                end
                prev_en = (spi_en === 1'b1);
                if (ss_cnt > 0) begin
                    ss_cnt--;
                    if (ss_cnt == 0) begin
                        spi_ss    = 1'b1;
                        last_rise = cyc;
                    end
                end else if (start_dly && spi_en !== 1'b1) begin
                    start_dly = 1'b0;
                    spi_ss    = 1'b0;
                    ss_cnt    = ser_low;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // Offer one sample starting at a negedge; returns the cycle count at the accept edge.
    task automatic push(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, output int acc_cyc);
        int k = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_addr  = a;
        while (s_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL push_timeout: s_ready=%0b, required 1 within 200 cycles", s_ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input logic [15:0] n);
        int k = 0;
        while ((frames_sent !== n || busy !== 1'b0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 3000) begin
            failures++;
            $display("FAIL wait_frames: frames_sent=%0d busy=%0b, required %0d and idle", frames_sent, busy, n);
        end
    endtask

    task automatic wait_en();
        int k = 0;
        while (spi_en !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 100) begin
            failures++;
            $display("FAIL wait_en: spi_en=%0b, required pulse within 100 cycles", spi_en);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_addr  = '0;
        resync  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready: got %0b required 1", s_ready); end
        if (spi_en !== 1'b0) begin failures++; $display("FAIL rst_spi_en: got %0b required 0", spi_en); end
        if (spi_clr !== 1'b0) begin failures++; $display("FAIL rst_spi_clr: got %0b required 0", spi_clr); end
        if (spi_data !== '0) begin failures++; $display("FAIL rst_spi_data: got %h required 0", spi_data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b required 0", busy); end
        if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b required 0", err); end
        if (frames_sent !== 16'd0) begin failures++; $display("FAIL rst_frames: got %0d required 0", frames_sent); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int acc;
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        ser_low = 18;
        push(12'hABC, 4'h2, acc);
        wait_frames(16'd1);
        checks += 7;
        if (got_data.size() != 1) begin failures++; $display("FAIL t1_count: got %0d pulses required 1", got_data.size()); end
        if (got_data[0] !== 20'h32ABC) begin failures++; $display("FAIL t1_data: got %h required 32abc", got_data[0]); end
        if (got_clr[0] !== 1'b1) begin failures++; $display("FAIL t1_clr: got %0b required 1", got_clr[0]); end
        if (got_cyc[0] - acc != 2) begin failures++; $display("FAIL t1_latency: got %0d required 2", got_cyc[0] - acc); end
        if (frames_sent !== 16'd1) begin failures++; $display("FAIL t1_frames: got %0d required 1", frames_sent); end
        if (spi_data !== 20'h32ABC || spi_clr !== 1'b1) begin
            failures++; $display("FAIL t1_hold: got data=%h clr=%0b required 32abc/1", spi_data, spi_clr);
        end
        if (err !== 1'b0) begin failures++; $display("FAIL t1_err: got %0b required 0", err); end
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] exp_d [3];
        exp_d[0] = 20'h31111;
        exp_d[1] = 20'h32222;
        exp_d[2] = 20'h33333;
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        ser_low = 4;
        s_valid = 1'b1; s_data = 12'h111; s_addr = 4'h1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_after1: got %0b required 1", s_ready); end
        s_data = 12'h222; s_addr = 4'h2;
        @(negedge clk);
        checks += 2;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_full: got %0b required 0", s_ready); end
        if (spi_en !== 1'b0) begin failures++; $display("FAIL t2_en_early: got %0b required 0", spi_en); end
        s_data = 12'h333; s_addr = 4'h3;
        @(negedge clk);
        checks += 2;
        if (spi_en !== 1'b1) begin failures++; $display("FAIL t2_en_issue: got %0b required 1", spi_en); end
        if (s_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_after_pop: got %0b required 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0;
        wait_frames(16'd4);
        checks++;
        if (got_data.size() != 3) begin failures++; $display("FAIL t2_count: got %0d pulses required 3", got_data.size()); end
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (got_data[i] !== exp_d[i]) begin failures++; $display("FAIL t2_data%0d: got %h required %h", i, got_data[i], exp_d[i]); end
            if (got_clr[i] !== 1'b0) begin failures++; $display("FAIL t2_clr%0d: got %0b required 0", i, got_clr[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (got_gap[i] < MIN_GAP + 1) begin
                failures++; $display("FAIL t2_gap%0d: got %0d cycles required >= %0d", i, got_gap[i], MIN_GAP + 1);
            end
        end
    endtask

    task automatic test_timeout();
        int acc;
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        ser_ignore = 1'b1;
        push(12'h5A5, 4'h4, acc);
        wait_en();
        repeat (TMO - 1) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL t3_err_early: got %0b required 0", err); end
        @(negedge clk);
        checks += 3;
        if (err !== 1'b1) begin failures++; $display("FAIL t3_err_set: got %0b required 1", err); end
        if (busy !== 1'b0) begin failures++; $display("FAIL t3_busy: got %0b required 0", busy); end
        if (frames_sent !== 16'd4) begin failures++; $display("FAIL t3_frames_drop: got %0d required 4", frames_sent); end
        ser_ignore = 1'b0;
        push(12'h0F0, 4'h5, acc);
        wait_frames(16'd5);
        checks += 3;
        if (got_data[1] !== 20'h350F0) begin failures++; $display("FAIL t3_next_data: got %h required 350f0", got_data[1]); end
        if (got_clr[1] !== 1'b0) begin failures++; $display("FAIL t3_next_clr: got %0b required 0", got_clr[1]); end
        if (err !== 1'b1) begin failures++; $display("FAIL t3_err_sticky: got %0b required 1", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL t3_err_clr: got %0b required 0", err); end
    endtask

    task automatic test_resync();
        int acc;
        logic [FRAME_W-1:0] exp_d [3];
        logic               exp_c [3];
        exp_d[0] = 20'h367AA; exp_c[0] = 1'b0;
        exp_d[1] = 20'h37123; exp_c[1] = 1'b1;
        exp_d[2] = 20'h38FED; exp_c[2] = 1'b0;
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        ser_low = 10;
        push(12'h7AA, 4'h6, acc);
        wait_en();
        repeat (3) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        push(12'h123, 4'h7, acc);
        push(12'hFED, 4'h8, acc);
        wait_frames(16'd8);
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (got_data[i] !== exp_d[i]) begin failures++; $display("FAIL t4_data%0d: got %h required %h", i, got_data[i], exp_d[i]); end
            if (got_clr[i] !== exp_c[i]) begin failures++; $display("FAIL t4_clr%0d: got %0b required %0b", i, got_clr[i], exp_c[i]); end
        end
    endtask

    task automatic test_wrap();
        int acc;
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        ser_low = 3;
        force dut.frames_sent = 16'hFFFF;
        #1;
        release dut.frames_sent;
        @(negedge clk);
        checks++;
        if (frames_sent !== 16'hFFFF) begin failures++; $display("FAIL t5_preload: got %h required ffff", frames_sent); end
        push(12'h246, 4'h1, acc);
        wait_frames(16'd0);
        checks += 2;
        if (frames_sent !== 16'd0) begin failures++; $display("FAIL t5_wrap: got %h required 0000", frames_sent); end
        if (got_data[0] !== 20'h31246) begin failures++; $display("FAIL t5_data: got %h required 31246", got_data[0]); end
    endtask

    task automatic test_reset_midframe();
        int acc;
        ser_low = 18;
        push(12'h456, 4'h9, acc);
        wait_en();
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL t6_busy_before: got %0b required 1", busy); end
        rst = 1'b1;
        #1;
        checks += 7;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL t6_s_ready: got %0b required 1", s_ready); end
        if (spi_en !== 1'b0) begin failures++; $display("FAIL t6_spi_en: got %0b required 0", spi_en); end
        if (spi_clr !== 1'b0) begin failures++; $display("FAIL t6_spi_clr: got %0b required 0", spi_clr); end
        if (spi_data !== '0) begin failures++; $display("FAIL t6_spi_data: got %h required 0", spi_data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy: got %0b required 0", busy); end
        if (err !== 1'b0) begin failures++; $display("FAIL t6_err: got %0b required 0", err); end
        if (frames_sent !== 16'd0) begin failures++; $display("FAIL t6_frames: got %0d required 0", frames_sent); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got_data.delete(); got_clr.delete(); got_cyc.delete(); got_gap.delete();
        push(12'h789, 4'hA, acc);
        wait_frames(16'd1);
        checks += 2;
        if (got_data[0] !== 20'h3A789) begin failures++; $display("FAIL t6_data: got %h required 3a789", got_data[0]); end
        if (got_clr[0] !== 1'b1) begin failures++; $display("FAIL t6_clr: got %0b required 1", got_clr[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_resync();
        test_wrap();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
